// File: rtl/arbitro_rr_mux4_pkg.sv
// Shared types and constants for the round-robin arbiter that owns a 4:1 data mux.
package arbitro_rr_mux4_pkg;

  localparam int unsigned NReq = 4;

  typedef enum logic {
    Libre   = 1'b0,
    Ocupado = 1'b1
  } estado_e;

endpackage

// File: rtl/arbitro_rr_mux4_mux.sv
// Plain 4:1 data multiplexer; select bit 2 is never set by the arbiter.
module Multiplexor4a1 #(
  parameter int unsigned ANCHO = 3
) (
  input  logic [ANCHO-1:0] A,
  input  logic [ANCHO-1:0] B,
  input  logic [ANCHO-1:0] C,
  input  logic [ANCHO-1:0] D,
  input  logic [2:0]       Selector,
  output logic [ANCHO-1:0] Salida
);

  always_comb begin
    case (Selector)
      3'd0:    Salida = A;
      3'd1:    Salida = B;
      3'd2:    Salida = C;
      3'd3:    Salida = D;
      default: Salida = '0;
    endcase
  end

endmodule

// File: rtl/arbitro_rr_mux4_prioridad.sv
// Rotating-priority picker: first set request bit scanning from ptr upwards, modulo 4.
module rr_prioridad
  import arbitro_rr_mux4_pkg::*;
(
  input  logic [NReq-1:0] req_i,
  input  logic [1:0]      ptr_i,
  output logic [1:0]      w_o,
  output logic            hay_req_o
);

  logic [1:0] idx;

  // Scan from the farthest offset down so the closest one to ptr wins.
  always_comb begin
    w_o = '0;
    idx = '0;
    for (int i = int'(NReq) - 1; i >= 0; i--) begin
      idx = ptr_i + 2'(i);
      if (req_i[idx]) begin
        w_o = idx;
      end
    end
  end

  assign hay_req_o = |req_i;

endmodule

// File: rtl/arbitro_rr_mux4.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, bursts bounded to MAX_RAFAGA.
module arbitro_rr_mux4
  import arbitro_rr_mux4_pkg::*;
#(
  parameter int unsigned ANCHO      = 3,
  parameter int unsigned MAX_RAFAGA = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NReq-1:0]  req,
  input  logic [ANCHO-1:0] A,
  input  logic [ANCHO-1:0] B,
  input  logic [ANCHO-1:0] C,
  input  logic [ANCHO-1:0] D,
  input  logic             listo_sal,
  output logic [NReq-1:0]  gnt,
  output logic [2:0]       Selector,
  output logic [ANCHO-1:0] Salida,
  output logic             salida_valida
);

  localparam logic [3:0] UltimoBeat = 4'(MAX_RAFAGA - 1);

  estado_e         estado_q;
  logic [1:0]      ptr_q;
  logic [3:0]      cuenta_q;
  logic [NReq-1:0] gnt_q;
  logic [1:0]      sel_q;

  logic [1:0] w;
  logic       hay_req;

  rr_prioridad u_prioridad (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .w_o       (w),
    .hay_req_o (hay_req)
  );

  // sel_q doubles as the owner index while Ocupado.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= Libre;
      ptr_q    <= '0;
      cuenta_q <= '0;
      gnt_q    <= '0;
      sel_q    <= '0;
    end else begin
      unique case (estado_q)
        Libre: begin
          if (hay_req) begin
            estado_q <= Ocupado;
            gnt_q    <= 4'b0001 << w;
            sel_q    <= w;
            cuenta_q <= '0;
            ptr_q    <= w + 2'd1;
          end
        end
        Ocupado: begin
          if (!req[sel_q]) begin
            estado_q <= Libre;
            gnt_q    <= '0;
          end else if (listo_sal) begin
            cuenta_q <= cuenta_q + 4'd1;
            if (cuenta_q == UltimoBeat) begin
              estado_q <= Libre;
              gnt_q    <= '0;
            end
          end
        end
        default: begin
          estado_q <= Libre;
          gnt_q    <= '0;
        end
      endcase
    end
  end

  assign gnt           = gnt_q;
  assign Selector      = {1'b0, sel_q};
  assign salida_valida = |(gnt_q & req);

  Multiplexor4a1 #(
    .ANCHO (ANCHO)
  ) u_mux (
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .Selector (Selector),
    .Salida   (Salida)
  );

endmodule

// File: tb/tb_arbitro_rr_mux4.sv
// Bench for arbitro_rr_mux4: fixed vectors, corner sequences and randomized traffic vs a model.
module tb_arbitro_rr_mux4;

  localparam int unsigned ANCHO      = 3;
  localparam int unsigned MAX_RAFAGA = 4;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [ANCHO-1:0] A, B, C, D;
  logic             listo_sal;
  logic [3:0]       gnt;
  logic [2:0]       Selector;
  logic [ANCHO-1:0] Salida;
  logic             salida_valida;

  int n_tests = 0;
  int n_fail  = 0;
  int beats   = 0;

  arbitro_rr_mux4 #(
    .ANCHO      (ANCHO),
    .MAX_RAFAGA (MAX_RAFAGA)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .A             (A),
    .B             (B),
    .C             (C),
    .D             (D),
    .listo_sal     (listo_sal),
    .gnt           (gnt),
    .Selector      (Selector),
    .Salida        (Salida),
    .salida_valida (salida_valida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the mux, where the scan starts, beats taken in this burst.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_owner <= 0;
      m_ptr   <= 0;
      m_cnt   <= 0;
    end else if (!m_busy) begin
      if (req != 4'b0000) begin
        m_busy  <= 1'b1;
        m_owner <= pick(req, m_ptr);
        m_ptr   <= (pick(req, m_ptr) + 1) % 4;
        m_cnt   <= 0;
      end
    end else if (!req[m_owner]) begin
      m_busy <= 1'b0;
    end else if (listo_sal) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == MAX_RAFAGA) m_busy <= 1'b0;
    end
  end

  function automatic logic [ANCHO-1:0] dato(input int o);
    case (o)
      0:       return A;
      1:       return B;
      2:       return C;
      default: return D;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle, then compare the DUT with the model after the edge.
  task automatic step(input logic r, input logic [3:0] q, input logic l);
    rst       = r;
    req       = q;
    listo_sal = l;
    if (!r && ((gnt & req) != 4'b0000) && listo_sal) beats++;
    @(posedge clk);
    #1;
    chk("model gnt", 32'(gnt), m_busy ? 32'(4'b0001 << m_owner) : 32'd0);
    chk("model valid", 32'(salida_valida), 32'(m_busy && req[m_owner]));
    if (m_busy) begin
      chk("model Selector", 32'(Selector), 32'(m_owner));
      chk("model Salida", 32'(Salida), 32'(dato(m_owner)));
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       listo;
    logic [3:0] gnt;
    logic [2:0] sel;
    logic       sel_chk;
    logic       valid;
  } vec_t;

  vec_t vecs[14];

  initial begin
    rst = 1'b1; req = '0; listo_sal = 1'b0;
    A = 3'd1; B = 3'd2; C = 3'd3; D = 3'd4;

    // Single requester bursts, then owner drop with a waiting requester.
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 3'd0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 3'd0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 3'd0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 3'd0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 3'd0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 3'd1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 3'd1, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 3'd1, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 4'b1000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 3'd3, 1'b1, 1'b1};

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].listo);
      chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d valid", i), 32'(salida_valida), 32'(vecs[i].valid));
      if (vecs[i].sel_chk) chk($sformatf("vec%0d Selector", i), 32'(Selector), 32'(vecs[i].sel));
    end

    // All four requesting: grants rotate 0,1,2,3,0 with one idle cycle between bursts.
    step(1'b1, 4'b0000, 1'b0);
    for (int g = 0; g < 5; g++) begin
      step(1'b0, 4'b1111, 1'b1);
      chk($sformatf("rot%0d gnt", g), 32'(gnt), 32'(4'b0001 << (g % 4)));
      chk($sformatf("rot%0d Selector", g), 32'(Selector), 32'(g % 4));
      for (int k = 0; k < 4; k++) begin
        step(1'b0, 4'b1111, 1'b1);
        chk($sformatf("rot%0d hold%0d", g, k), 32'(gnt),
            (k < 3) ? 32'(4'b0001 << (g % 4)) : 32'd0);
      end
    end

    // Downstream stall mid-burst must neither release nor count.
    step(1'b1, 4'b0000, 1'b0);
    beats = 0;
    step(1'b0, 4'b0100, 1'b1);
    step(1'b0, 4'b0100, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0100, 1'b0);
      chk($sformatf("stall%0d gnt", k), 32'(gnt), 32'h4);
    end
    step(1'b0, 4'b0100, 1'b1);
    step(1'b0, 4'b0100, 1'b1);
    chk("stall pre-last gnt", 32'(gnt), 32'h4);
    step(1'b0, 4'b0100, 1'b1);
    chk("stall release gnt", 32'(gnt), 32'h0);
    chk("stall beats", 32'(beats), 32'd4);

    // Reset in the middle of a burst clears everything and restarts the pointer.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b0010, 1'b1);
    step(1'b1, 4'b0010, 1'b1);
    chk("rst gnt", 32'(gnt), 32'h0);
    chk("rst Selector", 32'(Selector), 32'h0);
    chk("rst valid", 32'(salida_valida), 32'h0);
    step(1'b0, 4'b0100, 1'b1);
    chk("post-rst gnt", 32'(gnt), 32'h4);
    chk("post-rst Selector", 32'(Selector), 32'h2);

    // Pointer at 3: D first, then wrap to A.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    A = 3'b001; D = 3'b110;
    step(1'b0, 4'b1001, 1'b1);
    chk("wrap gnt D", 32'(gnt), 32'h8);
    chk("wrap Salida D", 32'(Salida), 32'h6);
    for (int k = 0; k < 4; k++) step(1'b0, 4'b1001, 1'b1);
    chk("wrap idle gnt", 32'(gnt), 32'h0);
    step(1'b0, 4'b1001, 1'b1);
    chk("wrap gnt A", 32'(gnt), 32'h1);
    chk("wrap Selector A", 32'(Selector), 32'h0);
    chk("wrap Salida A", 32'(Salida), 32'h1);

    // Randomized traffic with sticky requests, stalls and rare resets.
    step(1'b1, 4'b0000, 1'b0);
    begin
      logic [3:0] r;
      r = 4'b0000;
      for (int n = 0; n < 3000; n++) begin
        A = 3'($urandom); B = 3'($urandom); C = 3'($urandom); D = 3'($urandom);
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        step(($urandom_range(0, 63) == 0), r, ($urandom_range(0, 3) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
